// File: rtl/multi_operand_reduce_pkg.sv
// reduce_pkg: shared types for multi_operand_reduce.
//   mode_t  : reduction mode (SUM, MAC, MAX, MIN), values match the `mode` port encoding
//   state_t : controller states (IDLE, RUN, DONE)
package reduce_pkg;

  localparam logic [1:0] MODE_SUM = 2'b00;
  localparam logic [1:0] MODE_MAC = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;
  localparam logic [1:0] MODE_MIN = 2'b11;

  typedef enum logic [1:0] {
    SUM = MODE_SUM,
    MAC = MODE_MAC,
    MAX = MODE_MAX,
    MIN = MODE_MIN
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/multi_operand_reduce_if.sv
// multi_operand_reduce_if: request/response bundle of the reduction engine.
//   start    : request, accepted only while the engine is idle
//   mode     : 00 SUM, 01 MAC, 10 MAX, 11 MIN
//   operands : N elements of WIDTH bits, element k at [k*WIDTH +: WIDTH]
//   result   : final reduction, held until the next accepted request
//   done     : one-cycle pulse when result becomes valid
//   busy     : high while an operation is in flight (RUN or DONE)
//   overflow : sticky carry-out flag of the current SUM/MAC operation
// master = requester side, slave = engine side.
interface multi_operand_reduce_if #(
  parameter int WIDTH     = 32,
  parameter int N         = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(N)
) ();

  logic                   start;
  logic [1:0]             mode;
  logic [N*WIDTH-1:0]     operands;
  logic [ACC_WIDTH-1:0]   result;
  logic                   done;
  logic                   busy;
  logic                   overflow;

  modport master (
    output start, mode, operands,
    input  result, done, busy, overflow
  );

  modport slave (
    input  start, mode, operands,
    output result, done, busy, overflow
  );

endinterface

// File: rtl/multi_operand_reduce_step.sv
// reduce_step: one combinational reduction step.
//   mode     : operation of this step
//   acc      : current accumulator
//   a, b     : operands (b only matters for MAC, where the step adds a*b)
//   acc_next : accumulator after the step
//   carry    : carry out of ACC_WIDTH for SUM/MAC, always 0 for MAX/MIN
module reduce_step
  import reduce_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 67
) (
  input  mode_t                mode,
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] acc_next,
  output logic                 carry
);

  logic [2*WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    a_ext    = ACC_WIDTH'(a);
    // Zero-extends or truncates the full product to the accumulator width.
    prod_ext = ACC_WIDTH'(prod);
    addend   = (mode == MAC) ? prod_ext : a_ext;
    sum      = {1'b0, acc} + {1'b0, addend};

    acc_next = acc;
    carry    = 1'b0;
    case (mode)
      SUM, MAC: begin
        acc_next = sum[ACC_WIDTH-1:0];
        carry    = sum[ACC_WIDTH];
      end
      MAX:     acc_next = (a_ext > acc) ? a_ext : acc;
      MIN:     acc_next = (a_ext < acc) ? a_ext : acc;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/multi_operand_reduce.sv
// multi_operand_reduce: latches N operands on start and reduces them one step per
// clock (SUM, pairwise MAC, unsigned MAX, unsigned MIN).
//   clk : clock, all state on the rising edge
//   rst : synchronous active-low reset
//   bus : request/response bundle (slave side), see multi_operand_reduce_if
module multi_operand_reduce
  import reduce_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N         = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_operand_reduce_if.slave bus
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam int IW    = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(N / 2 - 1);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH-1:0]     op_in [N];
  logic [WIDTH-1:0]     ops_q [N];
  logic [WIDTH-1:0]     ops_d [N];

  logic [IW-1:0]        idx_a, idx_b;
  logic [CNT_W-1:0]     last_cnt;
  logic [ACC_WIDTH-1:0] step_acc;
  logic                 step_carry;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign op_in[gi] = bus.operands[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // MAC consumes operands in pairs (2*cnt, 2*cnt+1); the other modes walk one by one.
  always_comb begin
    idx_a    = (mode_q == MAC) ? IW'(cnt_q << 1) : IW'(cnt_q);
    idx_b    = idx_a | IW'(1);
    last_cnt = (mode_q == MAC) ? LAST_HALF : LAST_FULL;
  end

  reduce_step #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_step (
    .mode     (mode_q),
    .acc      (acc_q),
    .a        (ops_q[idx_a]),
    .b        (ops_q[idx_b]),
    .acc_next (step_acc),
    .carry    (step_carry)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    ops_d    = ops_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ops_d   = op_in;
          mode_d  = mode_t'(bus.mode);
          cnt_d   = '0;
          ovf_d   = 1'b0;
          // MIN starts from the largest value so the first operand always wins.
          acc_d   = (bus.mode == MODE_MIN) ? '1 : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        ovf_d = ovf_q | step_carry;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_cnt) begin
          result_d = step_acc;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= SUM;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand bank is always written on accept before use, so it needs no reset.
  always_ff @(posedge clk) begin
    ops_q <= ops_d;
  end

  assign bus.result   = result_q;
  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_multi_operand_reduce.sv
// tb_multi_operand_reduce: drives two engines (default accumulator width and a
// 32-bit accumulator) with identical requests and checks both against a
// transaction-level reference every cycle, plus literal expectations.
module tb_multi_operand_reduce;

  localparam int W  = 32;
  localparam int NN = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_operand_reduce_if #(.WIDTH(W), .N(NN), .ACC_WIDTH(2*W+3)) bus_a ();
  multi_operand_reduce_if #(.WIDTH(W), .N(NN), .ACC_WIDTH(32))    bus_b ();

  multi_operand_reduce #(.WIDTH(W), .N(NN), .ACC_WIDTH(2*W+3)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a));
  multi_operand_reduce #(.WIDTH(W), .N(NN), .ACC_WIDTH(32)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference reduction computed directly from the mode definitions.
  function automatic void ref_reduce(input int aw, input logic [1:0] md,
                                     input logic [NN*W-1:0] ops,
                                     output logic [127:0] res, output bit ovf);
    logic [127:0] mask, total, v, p;
    mask  = (128'd1 << aw) - 128'd1;
    total = '0;
    case (md)
      2'd0: for (int k = 0; k < NN; k++) total += 128'(ops[k*W +: W]);
      2'd1: for (int k = 0; k < NN/2; k++) begin
        p = 128'(ops[2*k*W +: W]) * 128'(ops[(2*k+1)*W +: W]);
        total += p & mask;
      end
      2'd2: for (int k = 0; k < NN; k++) begin
        v = 128'(ops[k*W +: W]);
        if (v > total) total = v;
      end
      default: begin
        total = mask;
        for (int k = 0; k < NN; k++) begin
          v = 128'(ops[k*W +: W]);
          if (v < total) total = v;
        end
      end
    endcase
    res = total & mask;
    ovf = (md[1] == 1'b0) && (total > mask);
  endfunction

  // Per-engine phase model: 0 idle, 1 running (m_rem steps left), 2 done cycle.
  int           m_phase [2];
  int           m_rem   [2];
  logic [127:0] m_res   [2];
  logic [127:0] m_exp   [2];
  bit           m_ovf   [2];
  bit           m_xovf  [2];
  bit           m_ovf_known [2];
  bit           started = 1'b0;

  initial begin : compare_proc
    logic             s_rst, s_start;
    logic [1:0]       s_mode;
    logic [NN*W-1:0]  s_ops;
    logic [127:0]     a_res;
    logic             a_done, a_busy, a_ovf;
    int               aw;
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = bus_a.start; s_mode = bus_a.mode; s_ops = bus_a.operands;
      if (!s_rst) started = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
        aw = (d == 0) ? 2*W+3 : 32;
        if (!s_rst) begin
          m_phase[d] = 0; m_res[d] = '0; m_ovf[d] = 1'b0; m_ovf_known[d] = 1'b1;
        end else begin
          case (m_phase[d])
            0: if (s_start) begin
              ref_reduce(aw, s_mode, s_ops, m_exp[d], m_xovf[d]);
              m_rem[d] = (s_mode == 2'd1) ? NN/2 : NN;
              m_phase[d] = 1;
              m_ovf_known[d] = 1'b0;
            end
            1: begin
              m_rem[d]--;
              if (m_rem[d] == 0) begin
                m_phase[d] = 2; m_res[d] = m_exp[d];
                m_ovf[d] = m_xovf[d]; m_ovf_known[d] = 1'b1;
              end
            end
            default: m_phase[d] = 0;
          endcase
        end
        if (started) begin
          if (d == 0) begin
            a_res = 128'(bus_a.result); a_done = bus_a.done; a_busy = bus_a.busy; a_ovf = bus_a.overflow;
          end else begin
            a_res = 128'(bus_b.result); a_done = bus_b.done; a_busy = bus_b.busy; a_ovf = bus_b.overflow;
          end
          chk($sformatf("dut%0d.done", d), 128'(a_done), 128'(m_phase[d] == 2));
          chk($sformatf("dut%0d.busy", d), 128'(a_busy), 128'(m_phase[d] != 0));
          chk($sformatf("dut%0d.result", d), a_res, m_res[d]);
          if (m_ovf_known[d]) chk($sformatf("dut%0d.overflow", d), 128'(a_ovf), 128'(m_ovf[d]));
        end
      end
    end
  end

  task automatic set_inputs(input logic st, input logic [1:0] md, input logic [NN*W-1:0] ops);
    bus_a.start = st; bus_a.mode = md; bus_a.operands = ops;
    bus_b.start = st; bus_b.mode = md; bus_b.operands = ops;
  endtask

  // Returns on the negedge following the accept edge; caller must be in IDLE.
  task automatic launch(input logic [1:0] md, input logic [NN*W-1:0] ops);
    @(negedge clk);
    set_inputs(1'b1, md, ops);
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    $display("[TB] accept mode=%0d ops=0x%0h", md, ops);
  endtask

  // Counts edges after the accept edge until done is seen; returns in the DONE cycle.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #2;
      if (bus_a.done === 1'b1) begin lat = k; break; end
    end
    n_tests++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL done_timeout: got no done within 40 edges, required a pulse");
    end else
      $display("[TB] done lat=%0d result=0x%0h ovf=%0b", lat, bus_a.result, bus_a.overflow);
  endtask

  logic [NN*W-1:0] base_ops, ones_ops, rnd_ops;
  int unsigned     base_vals [NN] = '{3, 2, 6, 4, 2, 3, 3, 1};

  initial begin : stim
    int lat;
    logic [1:0] md;
    for (int k = 0; k < NN; k++) begin
      base_ops[k*W +: W] = base_vals[k];
      ones_ops[k*W +: W] = 32'hFFFF_FFFF;
    end
    set_inputs(1'b0, 2'd0, '0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset.result", 128'(bus_a.result), 128'd0);
    chk("reset.busy", 128'(bus_a.busy), 128'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    launch(2'd0, base_ops); wait_done(lat);
    chk("sum.lat", 128'(lat), 128'd8);
    chk("sum.result", 128'(bus_a.result), 128'd24);
    chk("sum.ovf", 128'(bus_a.overflow), 128'd0);
    repeat (2) @(posedge clk);

    launch(2'd1, base_ops); wait_done(lat);
    chk("mac.lat", 128'(lat), 128'd4);
    chk("mac.result", 128'(bus_a.result), 128'd39);
    @(posedge clk);

    // MAX then MIN back to back: second accept at the first IDLE edge.
    launch(2'd2, base_ops); wait_done(lat);
    chk("max.result", 128'(bus_a.result), 128'd6);
    @(posedge clk);
    launch(2'd3, base_ops); wait_done(lat);
    chk("min.lat", 128'(lat), 128'd8);
    chk("min.result", 128'(bus_a.result), 128'd1);
    @(posedge clk);

    launch(2'd0, ones_ops); wait_done(lat);
    chk("sum32.result", 128'(bus_b.result), 128'hFFFF_FFF8);
    chk("sum32.ovf", 128'(bus_b.overflow), 128'd1);
    chk("sum67.result", 128'(bus_a.result), 128'h7_FFFF_FFF8);
    @(posedge clk);

    // start and new operands during RUN must be ignored.
    launch(2'd0, base_ops);
    repeat (2) @(negedge clk);
    set_inputs(1'b1, 2'd2, ones_ops);
    @(negedge clk);
    set_inputs(1'b0, 2'd3, '0);
    wait_done(lat);
    chk("ignore.result", 128'(bus_a.result), 128'd24);
    @(posedge clk);

    // Reset on the third RUN edge aborts the operation.
    launch(2'd0, base_ops);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("abort.result", 128'(bus_a.result), 128'd0);
    chk("abort.busy", 128'(bus_a.busy), 128'd0);
    chk("abort.done", 128'(bus_a.done), 128'd0);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);
    launch(2'd0, base_ops); wait_done(lat);
    chk("fresh.result", 128'(bus_a.result), 128'd24);
    @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      md = 2'($urandom_range(0, 3));
      for (int k = 0; k < NN; k++) begin
        case ($urandom_range(0, 3))
          0:       rnd_ops[k*W +: W] = 32'($urandom_range(0, 15));
          1:       rnd_ops[k*W +: W] = 32'hFFFF_FFFF;
          default: rnd_ops[k*W +: W] = $urandom;
        endcase
      end
      launch(md, rnd_ops);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        set_inputs(1'b1, 2'($urandom_range(0, 3)), {8{$urandom}});
        @(negedge clk);
        bus_a.start = 1'b0; bus_b.start = 1'b0;
      end
      wait_done(lat);
      repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_operand_reduce.md
# multi_operand_reduce

Parametrised successor to the fixed eight-operand start/done compute block. It latches N operands of WIDTH bits on `start` and reduces them sequentially, one step per clock, in one of four modes: sum, pairwise multiply-accumulate, unsigned max, or unsigned min. It presents a held `result` with a one-cycle `done` pulse. It sits behind the top-level controller in place of the fixed-function datapath.

## Interface
- `WIDTH`, 32: operand width in bits.
- `N`, 8: operand count; even, ≥ 2.
- `ACC_WIDTH`, 2*WIDTH+$clog2(N): accumulator and result width; must be ≥ WIDTH.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start` in 1: request; accepted only in IDLE.
- `mode` in 2: 00 SUM, 01 MAC, 10 MAX, 11 MIN; latched on accept.
- `operands` in N*WIDTH: flat bus; element k is `operands[k*WIDTH +: WIDTH]`; latched on accept.
- `result` out ACC_WIDTH: final reduction, held until the next accept.
- `done` out 1: one-cycle pulse when `result` becomes valid.
- `busy` out 1: high in RUN and DONE.
- `overflow` out 1: sticky per operation; set when a SUM/MAC step carries out of ACC_WIDTH.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE**
  - When `start` is 1 at an edge, latch `operands` and `mode` into an internal register bank, clear `cnt` and `overflow`, and go to RUN.
  - Initialise `acc` to 0 for SUM, MAC and MAX, and to all-ones for MIN.
- **RUN**
  - Each edge performs one step on the latched copy, then increments `cnt`.
  - SUM: `acc += op[cnt]`.
  - MAC: `acc += op[2*cnt] * op[2*cnt+1]`.
  - MAX: `acc = max(acc, op[cnt])`.
  - MIN: `acc = min(acc, op[cnt])`.
  - Step count L = N for SUM, MAX and MIN; L = N/2 for MAC.
  - On the edge that performs step L-1, load `result` with the final value and go to DONE.
- **DONE**
  - `done` is 1 for exactly this cycle; the next edge returns to IDLE.
- Arithmetic is unsigned throughout.
  - Operands are zero-extended to ACC_WIDTH.
  - The product is 2*WIDTH bits, truncated to ACC_WIDTH if ACC_WIDTH is smaller.
  - SUM/MAC wrap modulo 2^ACC_WIDTH, with `overflow` set on any carry-out.
  - MAX/MIN never set `overflow`.
- `start` in RUN or DONE is ignored. It does not queue, and latched operands and mode do not change mid-operation.
- Input changes on `operands`/`mode` after the accept edge have no effect.

## Timing
- Reset (`rst` = 0 at an edge) forces:
  - state IDLE;
  - `result` = 0, `done` = 0, `busy` = 0, `overflow` = 0;
  - `cnt` = 0, `acc` = 0.
- Reset overrides `start` in the same cycle.
- Reset mid-RUN aborts with no `done` pulse; `result` reads 0 afterwards.
- Latency: with the accept edge E0, `done` is high in the cycle after edge E_L.
  - SUM/MAX/MIN: 8 edges after E0 at N=8.
  - MAC: 4 edges after E0 at N=8.
- Throughput: the earliest next accept is the edge at the end of the DONE cycle + 1, i.e. E_{L+2}, since DONE returns to IDLE first.
- `busy` rises the cycle after E0 and falls the cycle after DONE.
- `result` changes only at E_L or on reset. `overflow` updates during RUN and is final when `done` = 1.

## Structure
- Package `reduce_pkg` holds:
  - `mode_t` enum (SUM, MAC, MAX, MIN);
  - `state_t` enum (IDLE, RUN, DONE);
  - the mode encoding constants.
- Sub-module `reduce_step`: purely combinational, one step. Inputs `mode`, `acc`, `a`, `b`; outputs `acc_next`, `carry`.
- The top level holds the FSM, `cnt` ($clog2(N)+1 bits), the operand register bank and the output registers.

## Test plan
- N=8, WIDTH=32, operands 3,2,6,4,2,3,3,1, SUM → `result` = 24, `done` one cycle high 8 edges after accept, `overflow` = 0.
- Same operands, MAC → `result` = 3·2+6·4+2·3+3·1 = 39, `done` 4 edges after accept.
- Same operands, MAX then MIN back-to-back (second `start` at the first legal IDLE edge) → `result` 6, then 1; two distinct `done` pulses.
- ACC_WIDTH=32, SUM of eight 0xFFFFFFFF → `result` = 0xFFFFFFF8, `overflow` = 1 at `done`.
- `start` re-asserted and `operands` changed during RUN → ignored; `result` matches the original operands; exactly one `done`.
- `rst` = 0 at the third RUN edge → next cycle all outputs 0, state IDLE, no `done`; a fresh SUM then completes normally with 24.
